axis_traffic_gen: RTL and testbench

Parametrised AXI-Stream traffic generator that feeds the user-side slave port of the 10G UDP stack in board-initiated transmit mode. It is the successor to the fixed test source. It adds runtime packet length, inter-packet gap, payload pattern and packet count. It also adds start/stop control, a sequence number in tuser, and status counters. It runs in the XGMII clock domain.

---
 rtl/axis_tg_pkg.sv | 32 +++
 rtl/axis_tg_prbs.sv | 49 ++++
 rtl/axis_traffic_gen.sv | 217 +++++++++++++++++++++
 tb/tb_axis_traffic_gen.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_tg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_tg_pkg                                                              |
// | Shared encodings and helpers for the AXI-Stream traffic generator.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package axis_tg_pkg;

    localparam logic [1:0] c_MODE_INC_BYTE = 2'd0;
    localparam logic [1:0] c_MODE_INC_WORD = 2'd1;
    localparam logic [1:0] c_MODE_PRBS     = 2'd2;
    localparam logic [1:0] c_MODE_CONST    = 2'd3;

    localparam logic [7:0] c_CONST_BYTE = 8'hA5;

    // Bit positions of the x^31 and x^28 terms in a 31-bit Fibonacci LFSR.
    localparam int c_PRBS_TAP_A = 30;
    localparam int c_PRBS_TAP_B = 27;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } tg_state_t;

    function automatic int f_kw(input int dw);
        return dw / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_tg_prbs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_tg_prbs                                                             |
// | Parallel PRBS-31 source: P_DATA_WIDTH bits per advance, seed reload.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axis_tg_prbs
    import axis_tg_pkg::*;
#(
    parameter int          P_DATA_WIDTH = 64,
    parameter logic [30:0] P_PRBS_SEED  = 31'h7FFF_FFFF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic                    i_adv,
    output logic [P_DATA_WIDTH-1:0] o_data
);

    logic [30:0] r_lfsr;
    logic [30:0] w_lfsr_next;

    // First generated bit lands in the MSB so it maps onto byte 0 of the beat.
    always_comb begin
        logic [30:0] v_s;
        logic        v_bit;
        v_s    = r_lfsr;
        v_bit  = 1'b0;
        o_data = '0;
        for (int i = 0; i < P_DATA_WIDTH; i++) begin
            v_bit                    = v_s[c_PRBS_TAP_A] ^ v_s[c_PRBS_TAP_B];
            o_data[P_DATA_WIDTH-1-i] = v_bit;
            v_s                      = {v_s[29:0], v_bit};
        end
        w_lfsr_next = v_s;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= P_PRBS_SEED;
        end else if (i_load) begin
            r_lfsr <= P_PRBS_SEED;
        end else if (i_adv) begin
            r_lfsr <= w_lfsr_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_traffic_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_traffic_gen                                                         |
// | Runtime-configurable AXI-Stream packet source with status counters.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axis_traffic_gen
    import axis_tg_pkg::*;
#(
    parameter int          P_DATA_WIDTH = 64,
    parameter int          P_USER_WIDTH = 32,
    parameter int          P_MAX_LEN    = 8192,
    parameter logic [30:0] P_PRBS_SEED  = 31'h7FFF_FFFF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic [15:0]               i_cfg_len,
    input  logic [15:0]               i_cfg_gap,
    input  logic [1:0]                i_cfg_mode,
    input  logic [31:0]               i_cfg_pkt_num,
    output logic [P_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [P_USER_WIDTH-1:0]   m_axis_tuser,
    output logic [P_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      s_axis_tready,
    output logic                      o_busy,
    output logic                      o_cfg_err,
    output logic [31:0]               o_pkt_cnt
);

    localparam int c_KW = f_kw(P_DATA_WIDTH);

    tg_state_t                r_state;
    logic [15:0]              r_len;
    logic [15:0]              r_gap;
    logic [1:0]               r_mode;
    logic [31:0]              r_pkt_num;
    logic [31:0]              r_pkt_cnt;
    logic [15:0]              r_seq;
    logic [15:0]              r_beat;
    logic [15:0]              r_gap_cnt;
    logic                     r_stop;
    logic                     r_cfg_err;
    logic [P_DATA_WIDTH-1:0]  r_tdata;
    logic [P_USER_WIDTH-1:0]  r_tuser;
    logic [c_KW-1:0]          r_tkeep;
    logic                     r_tlast;
    logic                     r_tvalid;

    logic                     w_hs;
    logic                     w_stop;
    logic                     w_done;
    logic                     w_load_beat;
    logic                     w_start_ok;
    logic [16:0]              w_num_beats;
    logic [15:0]              w_rem;
    logic [c_KW-1:0]          w_last_keep;
    logic [15:0]              w_bld_idx;
    logic [15:0]              w_bld_seq;
    logic                     w_bld_last;
    logic [c_KW-1:0]          w_bld_keep;
    logic [P_DATA_WIDTH-1:0]  w_bld_data;
    logic [P_DATA_WIDTH-1:0]  w_prbs_data;

    assign w_hs       = r_tvalid & s_axis_tready;
    assign w_stop     = r_stop | i_stop;
    assign w_done     = (r_pkt_num != 32'd0) && ((r_pkt_cnt + 32'd1) == r_pkt_num);
    assign w_start_ok = (i_cfg_len != 16'd0) && ({16'd0, i_cfg_len} <= 32'(P_MAX_LEN));

    // A new beat enters the output registers on the first SEND cycle, after
    // every non-final handshake, on a back-to-back packet and at the end of GAP.
    always_comb begin
        w_load_beat = 1'b0;
        case (r_state)
            S_LOAD:  w_load_beat = 1'b1;
            S_SEND:  w_load_beat = w_hs && (!r_tlast || (!w_stop && !w_done && r_gap == 16'd0));
            S_GAP:   w_load_beat = !w_stop && (r_gap_cnt == r_gap - 16'd1);
            default: w_load_beat = 1'b0;
        endcase
    end

    always_comb begin
        w_num_beats = 17'(({1'b0, r_len} + 17'(c_KW - 1)) / 17'(c_KW));
        w_rem       = 16'(r_len % 16'(c_KW));
        w_last_keep = '0;
        for (int k = 0; k < c_KW; k++) begin
            w_last_keep[c_KW-1-k] = (w_rem == 16'd0) || (16'(k) < w_rem);
        end
    end

    // Beat builder: contents of the beat that the next load will present.
    always_comb begin
        logic [P_DATA_WIDTH-1:0] v_word;
        logic [7:0]              v_byte;
        w_bld_idx  = (r_state == S_SEND && !r_tlast) ? r_beat + 16'd1 : 16'd0;
        w_bld_seq  = (r_state == S_SEND && r_tlast) ? r_seq + 16'd1 : r_seq;
        w_bld_last = ({1'b0, w_bld_idx} == (w_num_beats - 17'd1));
        w_bld_keep = w_bld_last ? w_last_keep : '1;
        v_word     = P_DATA_WIDTH'(w_bld_idx);
        v_byte     = 8'h00;
        w_bld_data = '0;
        for (int k = 0; k < c_KW; k++) begin
            case (r_mode)
                c_MODE_INC_BYTE: v_byte = 8'(32'(w_bld_idx) * 32'(c_KW) + 32'(k));
                c_MODE_INC_WORD: v_byte = v_word[P_DATA_WIDTH-1-8*k -: 8];
                c_MODE_PRBS:     v_byte = w_prbs_data[P_DATA_WIDTH-1-8*k -: 8];
                default:         v_byte = c_CONST_BYTE;
            endcase
            w_bld_data[P_DATA_WIDTH-1-8*k -: 8] = w_bld_keep[c_KW-1-k] ? v_byte : 8'h00;
        end
    end

    axis_tg_prbs #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_PRBS_SEED  (P_PRBS_SEED)
    ) u_prbs (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (r_state == S_IDLE && i_start && w_start_ok),
        .i_adv  (w_load_beat),
        .o_data (w_prbs_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_len     <= 16'd0;
            r_gap     <= 16'd0;
            r_mode    <= 2'd0;
            r_pkt_num <= 32'd0;
            r_pkt_cnt <= 32'd0;
            r_seq     <= 16'd0;
            r_beat    <= 16'd0;
            r_gap_cnt <= 16'd0;
            r_stop    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_tdata   <= '0;
            r_tuser   <= '0;
            r_tkeep   <= '0;
            r_tlast   <= 1'b0;
            r_tvalid  <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (!w_start_ok) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_len     <= i_cfg_len;
                            r_gap     <= i_cfg_gap;
                            r_mode    <= i_cfg_mode;
                            r_pkt_num <= i_cfg_pkt_num;
                            r_pkt_cnt <= 32'd0;
                            r_stop    <= 1'b0;
                            r_state   <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (i_stop) r_stop <= 1'b1;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (i_stop) r_stop <= 1'b1;
                    if (w_hs && r_tlast) begin
                        r_pkt_cnt <= r_pkt_cnt + 32'd1;
                        r_seq     <= r_seq + 16'd1;
                        if (w_stop || w_done) begin
                            r_state  <= S_IDLE;
                            r_stop   <= 1'b0;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                        end else if (r_gap != 16'd0) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= 16'd0;
                            r_tvalid  <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (w_stop) begin
                        r_state <= S_IDLE;
                        r_stop  <= 1'b0;
                        r_tlast <= 1'b0;
                    end else if (w_load_beat) begin
                        r_state <= S_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
            endcase
            if (w_load_beat) begin
                r_tvalid <= 1'b1;
                r_beat   <= w_bld_idx;
                r_tdata  <= w_bld_data;
                r_tkeep  <= w_bld_keep;
                r_tlast  <= w_bld_last;
                r_tuser  <= P_USER_WIDTH'({w_bld_seq, r_len});
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tvalid = r_tvalid;
    assign o_busy        = (r_state != S_IDLE);
    assign o_cfg_err     = r_cfg_err;
    assign o_pkt_cnt     = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axis_traffic_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axis_traffic_gen                                                      |
// | Scoreboard bench for axis_traffic_gen (64-bit data, default params).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_axis_traffic_gen;

    localparam logic [30:0] c_SEED = 31'h7FFF_FFFF;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [31:0] u;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] cfg_len = 16'd0;
    logic [15:0] cfg_gap = 16'd0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [31:0] cfg_pkt_num = 32'd0;
    logic [63:0] tdata;
    logic [31:0] tuser;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        busy;
    logic        cfg_err;
    logic [31:0] pkt_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    beat_t       sb[$];
    logic [30:0] m_lfsr = c_SEED;
    logic [15:0] m_seq = 16'd0;
    int          exp_gap = 0;
    bit          rand_ready = 1'b0;

    int          idle_run = 0;
    int          rx_pkts = 0;
    int          rx_beats = 0;
    bit          mid_pkt = 1'b0;
    bit          expect_sop = 1'b1;
    bit          have_prev = 1'b0;

    axis_traffic_gen dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_stop        (stop),
        .i_cfg_len     (cfg_len),
        .i_cfg_gap     (cfg_gap),
        .i_cfg_mode    (cfg_mode),
        .i_cfg_pkt_num (cfg_pkt_num),
        .m_axis_tdata  (tdata),
        .m_axis_tuser  (tuser),
        .m_axis_tkeep  (tkeep),
        .m_axis_tlast  (tlast),
        .m_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .o_busy        (busy),
        .o_cfg_err     (cfg_err),
        .o_pkt_cnt     (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference packet model: pushes every expected beat of one packet.
    task automatic push_pkt(input int len, input int mode);
        int nb;
        nb = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            beat_t       e;
            logic [63:0] pr;
            logic [63:0] wd;
            logic [7:0]  by;
            logic        nbit;
            pr = 64'd0;
            if (mode == 2) begin
                for (int i = 0; i < 64; i++) begin
                    nbit      = m_lfsr[30] ^ m_lfsr[27];
                    pr[63-i]  = nbit;
                    m_lfsr    = {m_lfsr[29:0], nbit};
                end
            end
            wd  = 64'(b);
            e.d = 64'd0;
            e.k = 8'd0;
            for (int k = 0; k < 8; k++) begin
                case (mode)
                    0:       by = 8'(b * 8 + k);
                    1:       by = wd[63-8*k -: 8];
                    2:       by = pr[63-8*k -: 8];
                    default: by = 8'hA5;
                endcase
                if (b * 8 + k < len) begin
                    e.k[7-k]        = 1'b1;
                    e.d[63-8*k -: 8] = by;
                end
            end
            e.l = (b == nb - 1);
            e.u = {m_seq, 16'(len)};
            sb.push_back(e);
        end
        m_seq = m_seq + 16'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_seq = 16'd0;
    endtask

    task automatic run_start(input int len, input int gap, input int mode, input int num);
        cfg_len     = 16'(len);
        cfg_gap     = 16'(gap);
        cfg_mode    = 2'(mode);
        cfg_pkt_num = 32'(num);
        m_lfsr      = c_SEED;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    always @(posedge clk) begin
        #1;
        tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: peeks the scoreboard every valid cycle (so stalled beats must
    // match too) and pops on handshake.
    always @(negedge clk) begin
        if (rst) begin
            mid_pkt    = 1'b0;
            expect_sop = 1'b1;
            have_prev  = 1'b0;
            idle_run   = 0;
            rx_pkts    = 0;
            rx_beats   = 0;
        end else begin
            if (mid_pkt) chk("no_bubble", 64'(tvalid), 64'd1);
            if (!tvalid) begin
                if (!mid_pkt) idle_run++;
            end else begin
                if (expect_sop) begin
                    if (have_prev) chk("gap_cycles", 64'(idle_run), 64'(exp_gap));
                    expect_sop = 1'b0;
                end
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(sb.size()), 64'd1);
                end else begin
                    chk("tdata", tdata, sb[0].d);
                    chk("tkeep", 64'(tkeep), 64'(sb[0].k));
                    chk("tlast", 64'(tlast), 64'(sb[0].l));
                    chk("tuser", 64'(tuser), 64'(sb[0].u));
                    if (tready) begin
                        void'(sb.pop_front());
                        rx_beats++;
                        if (tlast) begin
                            rx_pkts++;
                            mid_pkt    = 1'b0;
                            expect_sop = 1'b1;
                            have_prev  = 1'b1;
                            idle_run   = 0;
                        end else begin
                            mid_pkt = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        do_reset();
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_tdata", tdata, 64'd0);

        // Single 64-byte incrementing-byte packet.
        exp_gap = 0;
        push_pkt(64, 0);
        run_start(64, 0, 0, 1);
        chk("tvalid_lat0", 64'(tvalid), 64'd0);
        @(posedge clk);
        #1;
        chk("tvalid_lat1", 64'(tvalid), 64'd1);
        wait_idle(200);
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("t1_sb_left", 64'(sb.size()), 64'd0);

        // 61-byte packets with a 3-cycle gap, three of them.
        do_reset();
        exp_gap = 3;
        for (int p = 0; p < 3; p++) push_pkt(61, 0);
        run_start(61, 3, 0, 3);
        wait_idle(300);
        chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd3);
        chk("t2_rx_pkts", 64'(rx_pkts), 64'd3);
        chk("t2_sb_left", 64'(sb.size()), 64'd0);

        // Free-running with random backpressure, stopped after 5 packets.
        do_reset();
        exp_gap    = 0;
        rand_ready = 1'b1;
        for (int p = 0; p < 10; p++) push_pkt(16, 1);
        run_start(16, 0, 1, 0);
        n = 0;
        while (rx_pkts < 5 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) chk("t3_wait_timeout", 64'(rx_pkts), 64'd5);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_idle(300);
        rand_ready = 1'b0;
        chk("t3_rx_pkts", 64'(rx_pkts), 64'd6);
        chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd6);
        chk("t3_sb_left", 64'(sb.size()), 64'd8);
        chk("t3_busy", 64'(busy), 64'd0);
        sb.delete();

        // Illegal lengths are rejected.
        do_reset();
        for (int c = 0; c < 2; c++) begin
            run_start((c == 0) ? 0 : 9000, 0, 0, 1);
            chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
            chk("cfg_err_busy", 64'(busy), 64'd0);
            @(posedge clk);
            #1;
            chk("cfg_err_clear", 64'(cfg_err), 64'd0);
            chk("cfg_err_tvalid", 64'(tvalid), 64'd0);
            chk("cfg_err_busy2", 64'(busy), 64'd0);
        end

        // PRBS across two packets without reseeding in between.
        do_reset();
        exp_gap = 2;
        push_pkt(32, 2);
        push_pkt(32, 2);
        run_start(32, 2, 2, 2);
        m_lfsr = c_SEED;
        wait_idle(200);
        chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd2);
        chk("t5_sb_left", 64'(sb.size()), 64'd0);

        // Reset during beat 3 of 8.
        do_reset();
        exp_gap = 0;
        push_pkt(64, 3);
        run_start(64, 0, 3, 1);
        n = 0;
        while (rx_beats < 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("t6_wait_timeout", 64'(rx_beats), 64'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_tvalid", 64'(tvalid), 64'd0);
        chk("t6_tlast", 64'(tlast), 64'd0);
        chk("t6_tdata", tdata, 64'd0);
        chk("t6_tkeep", 64'(tkeep), 64'd0);
        chk("t6_tuser", 64'(tuser), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        sb.delete();
        m_seq = 16'd0;
        push_pkt(16, 0);
        run_start(16, 0, 0, 1);
        wait_idle(100);
        chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("t6_sb_left", 64'(sb.size()), 64'd0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
